// File: rtl/rr_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_pkg
// Shared definitions for the round-robin N-way registered multiplexer.
//   WIDTH_DEF / NUM_CH_DEF : default data width and channel count
//   clog2_safe(n)          : channel-index width, never less than 1 bit
//   rr_next(ptr, n)        : increment of a channel pointer, wrapping at n
// ---------------------------------------------------------------------------
package rr_mux_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int NUM_CH_DEF = 4;

    // Index width for n channels; a 2-channel mux still needs one index bit.
    function automatic int clog2_safe(input int n);
        int r;
        if (n > 2) begin
            r = $clog2(n);
        end else begin
            r = 1;
        end
        return r;
    endfunction

    // Wraps at n rather than at a power of two so odd channel counts work.
    function automatic int rr_next(input int ptr, input int n);
        int r;
        if (ptr + 1 >= n) begin
            r = 0;
        end else begin
            r = ptr + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_nway_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter built as a double-width masked priority
// encoder: the request vector is concatenated with itself and shifted down by
// the priority pointer, so the lowest set bit of the result is the first
// requester at or after the pointer, wrapping at NUM_CH.
// Ports:
//   req   [NUM_CH]  request per channel
//   ptr   [CH_W]    highest-priority channel
//   grant [NUM_CH]  one-hot grant (all zero when no request)
//   idx   [CH_W]    index of the granted channel
//   any   [1]       at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEF,
    localparam int CH_W   = clog2_safe(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    logic [CH_W-1:0]     ptr_eff_s;
    logic [2*NUM_CH-1:0] req_dbl_s;
    logic [NUM_CH-1:0]   rot_s;
    logic                found_s;
    logic [CH_W-1:0]     off_s;
    int                  sum_s;

    // Rotate requests so the pointer channel sits at bit 0, then find the first set bit.
    always_comb begin
        // An out-of-range pointer cannot occur in normal use; treat it as 0.
        if (int'(ptr) < NUM_CH) begin
            ptr_eff_s = ptr;
        end else begin
            ptr_eff_s = '0;
        end
        req_dbl_s = {req, req};
        rot_s     = NUM_CH'(req_dbl_s >> ptr_eff_s);
        found_s   = 1'b0;
        off_s     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found_s && rot_s[k]) begin
                found_s = 1'b1;
                off_s   = CH_W'(k);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Map the rotated offset back to an absolute channel index and one-hot grant.
    always_comb begin
        sum_s = int'(ptr_eff_s) + int'(off_s);
        if (sum_s >= NUM_CH) begin
            sum_s = sum_s - NUM_CH;
        end else begin
            sum_s = sum_s;
        end
        idx = CH_W'(sum_s);
        any = found_s;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = found_s && (idx == CH_W'(i));
        end
    end

endmodule

// File: rtl/rr_mux_nway.sv
// ---------------------------------------------------------------------------
// rr_mux_nway
// Registered N-way, WIDTH-bit multiplexer with per-channel valid/ready and
// round-robin arbitration. One output register; one word per cycle when the
// consumer keeps out_ready high.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid  [NUM_CH]         channel i presents data
//   in_ready  [NUM_CH]         channel i accepted this cycle (combinational)
//   in_data   [NUM_CH*WIDTH]   channel i at bits [i*WIDTH +: WIDTH]
//   out_valid                  output register holds a word
//   out_ready                  consumer accepts the word
//   out_data  [WIDTH]          registered selected word
//   out_chan  [CH_W]           channel that supplied out_data
// Optional feature (macro RR_MUX_SEL_OVERRIDE_EN):
//   sel_force [1], sel [CH_W]  while sel_force=1 only channel sel may be
//                              granted; forced transfers leave the
//                              round-robin pointer untouched.
// ---------------------------------------------------------------------------
module rr_mux_nway
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int NUM_CH = NUM_CH_DEF,
    localparam int CH_W   = clog2_safe(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
`ifdef RR_MUX_SEL_OVERRIDE_EN
    input  logic                    sel_force,
    input  logic [CH_W-1:0]         sel,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_chan
);

    logic              out_valid_r;
    logic [WIDTH-1:0]  out_data_r;
    logic [CH_W-1:0]   out_chan_r;
    logic [CH_W-1:0]   rr_ptr_r;

    logic [NUM_CH-1:0] arb_grant_s;
    logic [CH_W-1:0]   arb_idx_s;
    logic              arb_any_s;

    logic [NUM_CH-1:0] g_onehot_s;
    logic [CH_W-1:0]   g_idx_s;
    logic              g_any_s;
    logic              forced_s;

    logic              load_s;
    logic              xfer_s;
    logic [WIDTH-1:0]  sel_data_s;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req   (in_valid),
        .ptr   (rr_ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

`ifdef RR_MUX_SEL_OVERRIDE_EN
    logic force_hit_s;

    // Static select overrides the arbiter; a select beyond NUM_CH matches no channel.
    always_comb begin
        force_hit_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((sel == CH_W'(i)) && in_valid[i]) begin
                force_hit_s = 1'b1;
            end else begin
                force_hit_s = force_hit_s;
            end
        end
        forced_s = sel_force;
        if (sel_force) begin
            g_any_s = force_hit_s;
            g_idx_s = sel;
            for (int i = 0; i < NUM_CH; i++) begin
                g_onehot_s[i] = force_hit_s && (sel == CH_W'(i));
            end
        end else begin
            g_any_s    = arb_any_s;
            g_idx_s    = arb_idx_s;
            g_onehot_s = arb_grant_s;
        end
    end
`else
    // Pure round-robin: the arbiter result is the grant.
    always_comb begin
        forced_s   = 1'b0;
        g_any_s    = arb_any_s;
        g_idx_s    = arb_idx_s;
        g_onehot_s = arb_grant_s;
    end
`endif

    // Handshake: accept only when the output register is free or draining, never in reset.
    always_comb begin
        load_s = !out_valid_r || out_ready;
        xfer_s = load_s && g_any_s && rst_n;
        if (xfer_s) begin
            in_ready = g_onehot_s;
        end else begin
            in_ready = '0;
        end
    end

    // AND-OR data mux driven by the one-hot grant.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{g_onehot_s[i]}});
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
            rr_ptr_r    <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_chan_r  <= g_idx_s;
            if (!forced_s) begin
                rr_ptr_r <= CH_W'(rr_next(int'(g_idx_s), NUM_CH));
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end else if (load_s) begin
            // Drained with nothing to refill: data and channel keep their last value.
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;

endmodule

// File: doc/rr_mux_nway.md
Name: rr_mux_nway

Overview:
- Parametrised, registered N-way, W-bit multiplexer with per-channel valid/ready handshake and round-robin arbitration.
- Generalises the 4-way 16-bit combinational mux: any width and channel count, one pipeline register, fair selection instead of a static select.
- Sits between multiple producers (register-file read ports, ALU result sources) and a single consumer on the 16-bit datapath.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- NUM_CH, 4, number of input channels (>=2).
- CH_W, $clog2(NUM_CH), derived localparam; width of channel index. Not overridable.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_CH  bit i: channel i presents data.
- in_ready  out  NUM_CH  bit i: channel i accepted this cycle. Combinational.
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  registered selected word.
- out_chan  out  CH_W  index of the channel that supplied out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, round-robin pointer rr_ptr=0 (channel 0 highest priority). in_ready=0 while in reset.
- load = !out_valid | out_ready. Output register may capture only when load=1.
- Arbitration is combinational. Search channels starting at rr_ptr, ascending, wrapping modulo NUM_CH. The first channel with in_valid=1 is the grant g.
- in_ready[i] = load & any_valid & (i==g). At most one bit of in_ready is set. in_ready does not depend on in_ready itself. in_ready may depend on out_ready, a combinational path that is acceptable.
- Transfer on channel i: in_valid[i] & in_ready[i].
- On transfer at edge: out_data<=in_data[g], out_chan<=g, out_valid<=1, rr_ptr<=(g+1) mod NUM_CH.
- No transfer, with load=1 and out_ready=1: out_valid<=0. out_data and out_chan hold their previous value.
- Stall (out_valid=1, out_ready=0): out_data, out_chan and rr_ptr all hold. in_ready=0.
- Latency: one cycle from input transfer to out_valid. Throughput: one word per cycle when out_ready is held high.
- Simultaneous drain and fill: permitted in the same cycle, giving back-to-back output with no bubble.
- Wrap-around: a grant to channel NUM_CH-1 sets rr_ptr=0.
- rr_ptr advances only on a transfer. Idle cycles do not move priority.
- Fairness: a continuously valid channel is granted within NUM_CH transfers.
- Non-power-of-two NUM_CH: pointer arithmetic wraps at NUM_CH, not at 2^CH_W.
- Reset mid-operation: any in-flight word is dropped and the pointer returns to 0. Inputs are not acknowledged during reset.
- Producers must hold in_data stable while in_valid=1 and no transfer has occurred. The block does not check this.

Optional Feature:
- Macro: RR_MUX_SEL_OVERRIDE_EN.
- Defined:
  - Adds ports sel_force (in, 1) and sel (in, CH_W).
  - While sel_force=1, g=sel when in_valid[sel]=1. Otherwise there is no grant.
  - rr_ptr is not updated by forced transfers.
  - sel >= NUM_CH means no grant.
  - This is static-select mux behaviour with a register stage.
- Not defined: the ports do not exist and arbitration is pure round-robin.

Decomposition:
- Shared package rr_mux_pkg holds:
  - function clog2_safe (returns 1 for NUM_CH<=2);
  - function rr_next(ptr, n), returning wrapped increment;
  - localparam defaults WIDTH_DEF=16, NUM_CH_DEF=4.
- One sub-module is natural: rr_arbiter.
  - Inputs: req[NUM_CH], ptr.
  - Outputs: one-hot grant, index, any.
  - Implemented as a double-width masked priority encoder.
- rr_mux_nway instantiates rr_arbiter and contains the data mux, output register and pointer.

Test Plan:
- Reset: rst_n low with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0. Release, then the first edge captures channel 0; out_chan=0.
- Round-robin: NUM_CH=4, all valid, data i=16'hA000+i, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=4'b0000, rr_ptr unchanged. Release gives the next grant next cycle.
- Sparse requests: only ch1 and ch3 valid, rr_ptr=2 -> grant ch3, then ch1, then ch3.
- Wrap and odd count: NUM_CH=3, WIDTH=8, all valid -> out_chan 0,1,2,0. No grant to index 3.
- Override (RR_MUX_SEL_OVERRIDE_EN): sel_force=1, sel=2, all valid -> ch2 granted every cycle, rr_ptr frozen. With sel=2 and in_valid[2]=0 -> no transfer, out_valid drops after drain.
